// File: rtl/fso_pkg.sv
// Shared constants and types for the FSO receive path (bit aligner and deframer).
package fso_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned OFF_W          = 5;
    localparam int unsigned FRAME_OVERHEAD = 4;

    localparam logic [WORD_W-1:0] PRE_HI = 32'hEB94BDA3;
    localparam logic [WORD_W-1:0] PRE_LO = 32'hF6AAEE24;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    typedef struct packed {
        logic              user;
        logic [WORD_W-1:0] data;
    } aligned_word_t;

endpackage

// File: rtl/fso_bit_aligner_if.sv
// Raw gearbox word stream in, word-aligned stream out. master = aligner side, slave = environment side.
interface fso_bit_aligner_if;
    import fso_pkg::*;

    logic [WORD_W-1:0] s_tdata;
    logic              s_tvalid;
    logic [WORD_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tuser;

    modport master (
        input  s_tdata, s_tvalid,
        output m_tdata, m_tvalid, m_tuser
    );

    modport slave (
        output s_tdata, s_tvalid,
        input  m_tdata, m_tvalid, m_tuser
    );

endinterface

// File: rtl/fso_bit_rot32.sv
// Combinational 32-way candidate generator with lowest-offset preamble-HI priority match.
module fso_bit_rot32
    import fso_pkg::*;
(
    input  logic [WORD_W-1:0] prev_word,
    input  logic [WORD_W-1:0] cur_word,
    input  logic [OFF_W-1:0]  off,
    input  logic              use_match,
    output logic              match_valid,
    output logic [OFF_W-1:0]  match_k,
    output logic [WORD_W-1:0] cand
);

    logic [2*WORD_W-1:0] window;
    logic [WORD_W-1:0]   cands [WORD_W];

    assign window = {prev_word, cur_word};

    always_comb begin
        for (int k = 0; k < WORD_W; k++) begin
            cands[k] = window[2*WORD_W-1-k -: WORD_W];
        end
    end

    // Scan high to low so the lowest matching offset is the one left standing.
    always_comb begin
        match_valid = 1'b0;
        match_k     = '0;
        for (int k = WORD_W - 1; k >= 0; k--) begin
            if (cands[k] == PRE_HI) begin
                match_valid = 1'b1;
                match_k     = OFF_W'(k);
            end
        end
    end

    assign cand = cands[use_match ? match_k : off];

endmodule

// File: rtl/fso_bit_aligner.sv
// Bit aligner: finds the preamble bit offset in the raw gearbox stream and forwards word-aligned data.
module fso_bit_aligner
    import fso_pkg::*;
#(
    parameter int unsigned PAYLOAD_WORDS = 16,
    parameter int unsigned SLIP_CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_link_up,
    input  logic                  i_realign_req,
    fso_bit_aligner_if.master     bus,
    input  logic [3:0]            cfg_verify_frames,
    input  logic [7:0]            cfg_miss_th,
    output logic                  o_bit_locked,
    output logic                  o_bit_locked_soft,
    output logic [OFF_W-1:0]      o_bit_offset,
    output logic [SLIP_CNT_W-1:0] o_slip_cnt
);

    localparam int unsigned FRAME_WORDS = PAYLOAD_WORDS + FRAME_OVERHEAD;
    localparam int unsigned POS_W       = $clog2(FRAME_WORDS);

    align_state_e          state, state_n;
    logic [WORD_W-1:0]     prev_word;
    logic [POS_W-1:0]      pos, pos_n;
    logic [3:0]            good_cnt, good_n;
    logic [7:0]            miss_cnt, miss_n;
    logic                  hi_ok, hi_ok_n;
    logic [OFF_W-1:0]      off_n;
    logic [SLIP_CNT_W-1:0] slip_n;
    logic                  emit, emit_user;
    aligned_word_t         out_word;
    logic                  out_valid;

    logic                  hunting;
    logic                  match_valid;
    logic [OFF_W-1:0]      match_k;
    logic [WORD_W-1:0]     cand;

    assign hunting = (state == SEARCH);

    fso_bit_rot32 u_rot (
        .prev_word   (prev_word),
        .cur_word    (bus.s_tdata),
        .off         (o_bit_offset),
        .use_match   (hunting),
        .match_valid (match_valid),
        .match_k     (match_k),
        .cand        (cand)
    );

    logic       force_search, accept, at_pos1, pre_hit;
    logic [4:0] good_inc;
    logic [8:0] miss_inc;
    logic [3:0] verify_th;
    logic [7:0] miss_th;
    logic       verify_done, miss_done;

    assign force_search = !i_link_up || i_realign_req;
    assign accept       = bus.s_tvalid;
    assign at_pos1      = (pos == POS_W'(1));
    assign pre_hit      = hi_ok && (cand == PRE_LO);
    assign good_inc     = {1'b0, good_cnt} + 5'd1;
    assign miss_inc     = {1'b0, miss_cnt} + 9'd1;
    assign verify_th    = (cfg_verify_frames == 4'd0) ? 4'd1 : cfg_verify_frames;
    assign miss_th      = (cfg_miss_th == 8'd0) ? 8'd1 : cfg_miss_th;
    assign verify_done  = (good_inc >= {1'b0, verify_th});
    assign miss_done    = (miss_inc >= {1'b0, miss_th});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEARCH;
        else        state <= state_n;
    end

    // Preamble decisions are taken only on the LO word (pos 1) of each frame.
    always_comb begin
        state_n = state;
        if (force_search) begin
            state_n = SEARCH;
        end else if (accept) begin
            case (state)
                SEARCH: if (match_valid) state_n = VERIFY;
                VERIFY: if (at_pos1) state_n = !pre_hit ? SEARCH : (verify_done ? LOCKED : VERIFY);
                LOCKED: if (at_pos1 && !pre_hit && miss_done) state_n = SEARCH;
                default: state_n = SEARCH;
            endcase
        end
    end

    always_comb begin
        pos_n     = pos;
        good_n    = good_cnt;
        miss_n    = miss_cnt;
        hi_ok_n   = hi_ok;
        off_n     = o_bit_offset;
        slip_n    = o_slip_cnt;
        emit      = 1'b0;
        emit_user = 1'b0;
        if (!force_search && accept) begin
            if (hunting) begin
                if (match_valid) begin
                    off_n     = match_k;
                    emit      = 1'b1;
                    emit_user = 1'b1;
                    pos_n     = POS_W'(1);
                    hi_ok_n   = 1'b1;
                    good_n    = '0;
                end
            end else begin
                emit      = 1'b1;
                emit_user = (pos == '0);
                pos_n     = (pos == POS_W'(FRAME_WORDS - 1)) ? '0 : pos + POS_W'(1);
                if (pos == '0) hi_ok_n = (cand == PRE_HI);
                if (at_pos1) begin
                    if (state == VERIFY && pre_hit) begin
                        good_n = good_inc[3:0];
                    end else if (state == LOCKED) begin
                        miss_n = pre_hit ? '0 : miss_inc[7:0];
                        if (!pre_hit && miss_done && o_slip_cnt != '1) slip_n = o_slip_cnt + SLIP_CNT_W'(1);
                    end
                end
            end
        end
        if (state_n == SEARCH) begin
            pos_n   = '0;
            good_n  = '0;
            miss_n  = '0;
            hi_ok_n = 1'b0;
        end else if (state == VERIFY && state_n == LOCKED) begin
            miss_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_word         <= '0;
            pos               <= '0;
            good_cnt          <= '0;
            miss_cnt          <= '0;
            hi_ok             <= 1'b0;
            o_bit_offset      <= '0;
            o_slip_cnt        <= '0;
            out_word          <= '0;
            out_valid         <= 1'b0;
            o_bit_locked      <= 1'b0;
            o_bit_locked_soft <= 1'b0;
        end else begin
            if (accept) prev_word <= bus.s_tdata;
            pos               <= pos_n;
            good_cnt          <= good_n;
            miss_cnt          <= miss_n;
            hi_ok             <= hi_ok_n;
            o_bit_offset      <= off_n;
            o_slip_cnt        <= slip_n;
            out_valid         <= emit;
            out_word.user     <= emit && emit_user;
            if (emit) out_word.data <= cand;
            o_bit_locked      <= (state_n == LOCKED) && (miss_n == '0);
            o_bit_locked_soft <= (state_n == LOCKED);
        end
    end

    assign bus.m_tdata  = out_word.data;
    assign bus.m_tuser  = out_word.user;
    assign bus.m_tvalid = out_valid;

endmodule

// File: tb/tb_fso_bit_aligner.sv
// Randomised bench for fso_bit_aligner: bit-level stream builder plus a behavioural alignment model.
module tb_fso_bit_aligner;
    import fso_pkg::*;

    localparam int unsigned PAYLOAD_WORDS = 16;
    localparam int unsigned SLIP_CNT_W    = 16;
    localparam int          FRAME_WORDS   = PAYLOAD_WORDS + 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  i_link_up;
    logic                  i_realign_req;
    logic [3:0]            cfg_verify_frames;
    logic [7:0]            cfg_miss_th;
    logic                  o_bit_locked;
    logic                  o_bit_locked_soft;
    logic [4:0]            o_bit_offset;
    logic [SLIP_CNT_W-1:0] o_slip_cnt;

    fso_bit_aligner_if bus ();

    fso_bit_aligner #(
        .PAYLOAD_WORDS (PAYLOAD_WORDS),
        .SLIP_CNT_W    (SLIP_CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_link_up         (i_link_up),
        .i_realign_req     (i_realign_req),
        .bus               (bus),
        .cfg_verify_frames (cfg_verify_frames),
        .cfg_miss_th       (cfg_miss_th),
        .o_bit_locked      (o_bit_locked),
        .o_bit_locked_soft (o_bit_locked_soft),
        .o_bit_offset      (o_bit_offset),
        .o_slip_cnt        (o_slip_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] md_prev;
    int          md_state;   // 0 hunting, 1 confirming, 2 locked
    int          md_off, md_pos, md_good, md_miss, md_slip;
    bit          md_hi;
    logic        exp_v, exp_user, exp_locked, exp_soft;
    logic [31:0] exp_data;

    function automatic void md_hunt();
        md_state = 0; md_pos = 0; md_good = 0; md_miss = 0; md_hi = 0;
    endfunction

    function automatic void model_reset();
        md_prev = '0; md_off = 0; md_slip = 0;
        md_hunt();
        exp_v = 0; exp_user = 0; exp_locked = 0; exp_soft = 0; exp_data = '0;
    endfunction

    function automatic void model_step(input bit v, input logic [31:0] d, input bit rr, input bit lu);
        logic [63:0] win;
        logic [31:0] c;
        int          found, p, vf, mt;
        bit          hit;
        vf    = (cfg_verify_frames == 0) ? 1 : int'(cfg_verify_frames);
        mt    = (cfg_miss_th == 0) ? 1 : int'(cfg_miss_th);
        exp_v = 0; exp_user = 0;
        win   = {md_prev, d};
        if (!lu || rr) begin
            md_hunt();
        end else if (v) begin
            if (md_state == 0) begin
                found = -1;
                for (int k = 0; k < 32 && found < 0; k++)
                    if (win[63-k -: 32] == PRE_HI) found = k;
                if (found >= 0) begin
                    md_off = found; exp_v = 1; exp_user = 1; exp_data = PRE_HI;
                    md_state = 1; md_pos = 1; md_hi = 1; md_good = 0;
                end
            end else begin
                c = win[63-md_off -: 32];
                exp_v = 1; exp_data = c; exp_user = (md_pos == 0);
                p = md_pos;
                md_pos = (md_pos + 1) % FRAME_WORDS;
                if (p == 0) md_hi = (c == PRE_HI);
                if (p == 1) begin
                    hit = md_hi && (c == PRE_LO);
                    if (md_state == 1) begin
                        if (!hit) md_hunt();
                        else begin
                            md_good++;
                            if (md_good >= vf) begin md_state = 2; md_miss = 0; end
                        end
                    end else if (hit) begin
                        md_miss = 0;
                    end else begin
                        md_miss++;
                        if (md_miss >= mt) begin
                            md_hunt();
                            if (md_slip < (1 << SLIP_CNT_W) - 1) md_slip++;
                        end
                    end
                end
            end
        end
        if (v) md_prev = d;
        exp_locked = (md_state == 2) && (md_miss == 0);
        exp_soft   = (md_state == 2);
    endfunction

    // ---------------- stream builder ----------------
    bit          bq[$];
    logic [31:0] txq[$];
    bit          track_tx, await_hi, saw_unlocked, saw_soft_drop;
    int          acc_cnt, first_hi_acc, first_lock_acc;

    task automatic push_bits(input int n);
        for (int i = 0; i < n; i++) bq.push_back(1'($urandom));
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) bq.push_back(w[i]);
        txq.push_back(w);
    endtask

    task automatic push_frame(input bit corrupt);
        logic [31:0] hi;
        hi = PRE_HI;
        if (corrupt) hi = hi ^ (32'd1 << $urandom_range(31));
        push_word(hi);
        push_word(PRE_LO);
        for (int i = 0; i < FRAME_WORDS - 2; i++) push_word($urandom);
    endtask

    function automatic logic [31:0] pop_word();
        logic [31:0] w;
        for (int i = 31; i >= 0; i--) w[i] = bq.pop_front();
        return w;
    endfunction

    task automatic step(input bit v, input logic [31:0] d, input bit rr, input bit lu);
        int cur;
        bus.s_tvalid = v; bus.s_tdata = d; i_realign_req = rr; i_link_up = lu;
        model_step(v, d, rr, lu);
        @(posedge clk); #1;
        check("m_tvalid", 64'(bus.m_tvalid), 64'(exp_v));
        if (exp_v) begin
            check("m_tdata", 64'(bus.m_tdata), 64'(exp_data));
            check("m_tuser", 64'(bus.m_tuser), 64'(exp_user));
        end
        check("bit_locked", 64'(o_bit_locked), 64'(exp_locked));
        check("bit_locked_soft", 64'(o_bit_locked_soft), 64'(exp_soft));
        check("bit_offset", 64'(o_bit_offset), 64'(md_off));
        check("slip_cnt", 64'(o_slip_cnt), 64'(md_slip));
        if (track_tx && bus.m_tvalid && txq.size() > 0) check("payload", 64'(bus.m_tdata), 64'(txq.pop_front()));
        if (await_hi && bus.m_tvalid) begin
            check("realign_first_tuser", 64'(bus.m_tuser), 64'd1);
            await_hi = 0;
        end
        if (!o_bit_locked) saw_unlocked = 1;
        if (!o_bit_locked_soft) saw_soft_drop = 1;
        if (v) begin
            cur = acc_cnt;
            acc_cnt++;
            if (bus.m_tvalid && bus.m_tuser && first_hi_acc < 0) first_hi_acc = cur;
            if (o_bit_locked && first_lock_acc < 0) first_lock_acc = cur;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int gap_pct, input int rr_word);
        int w;
        w = 0;
        while (bq.size() >= 32) begin
            while (int'($urandom_range(99)) < gap_pct) step(0, $urandom, 0, 1);
            step(1, pop_word(), (w == rr_word), 1);
            if (w == rr_word) begin
                check("realign_locked", 64'(o_bit_locked), 64'd0);
                check("realign_soft", 64'(o_bit_locked_soft), 64'd0);
                await_hi = 1;
            end
            w++;
        end
    endtask

    task automatic do_reset();
        rst_n = 0; bus.s_tvalid = 0; bus.s_tdata = '0; i_realign_req = 0; i_link_up = 1;
        model_reset();
        bq.delete(); txq.delete();
        acc_cnt = 0; first_hi_acc = -1; first_lock_acc = -1;
        track_tx = 0; await_hi = 0; saw_unlocked = 0; saw_soft_drop = 0;
        repeat (2) @(negedge clk);
        check("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
        check("rst_m_tuser", 64'(bus.m_tuser), 64'd0);
        check("rst_m_tdata", 64'(bus.m_tdata), 64'd0);
        check("rst_locked", 64'(o_bit_locked), 64'd0);
        check("rst_soft", 64'(o_bit_locked_soft), 64'd0);
        check("rst_offset", 64'(o_bit_offset), 64'd0);
        check("rst_slip", 64'(o_slip_cnt), 64'd0);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic run_clean(input int r);
        do_reset();
        track_tx = 1;
        push_bits(r);
        repeat (4) push_frame(0);
        drain(0, -1);
        track_tx = 0;
        check("clean_hi_idx", 64'(first_hi_acc), 64'd1);
        check("clean_lock_idx", 64'(first_lock_acc), 64'd22);
        check("clean_offset", 64'(o_bit_offset), 64'(r));
        check("clean_locked", 64'(o_bit_locked), 64'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cfg_verify_frames = 4'd2;
        cfg_miss_th       = 8'd3;

        run_clean(0);
        run_clean(31);
        run_clean(13);

        // Fade: two lost preambles are tolerated, three cause a slip.
        saw_unlocked = 0; saw_soft_drop = 0;
        push_frame(1); push_frame(1); push_frame(0); push_frame(0);
        drain(0, -1);
        check("fade2_unlocked_seen", 64'(saw_unlocked), 64'd1);
        check("fade2_soft_kept", 64'(saw_soft_drop), 64'd0);
        check("fade2_relocked", 64'(o_bit_locked), 64'd1);
        check("fade2_slip", 64'(o_slip_cnt), 64'd0);
        saw_soft_drop = 0;
        repeat (3) push_frame(1);
        repeat (2) push_frame(0);
        drain(0, -1);
        check("fade3_soft_dropped", 64'(saw_soft_drop), 64'd1);
        check("fade3_slip", 64'(o_slip_cnt), 64'd1);
        check("fade3_relocked", 64'(o_bit_locked), 64'd1);

        // Realign on the LO word that would otherwise hit, then move the rotation to 7.
        repeat (2) push_frame(0);
        drain(0, 2);
        push_bits(26);
        repeat (4) push_frame(0);
        drain(0, -1);
        check("realign_offset", 64'(o_bit_offset), 64'd7);
        check("realign_relocked", 64'(o_bit_locked), 64'd1);
        check("realign_slip", 64'(o_slip_cnt), 64'd1);

        // Idle gaps: lock timing is counted in accepted words only.
        do_reset();
        push_bits(19);
        repeat (4) push_frame(0);
        drain(30, -1);
        check("gap_hi_idx", 64'(first_hi_acc), 64'd1);
        check("gap_lock_idx", 64'(first_lock_acc), 64'd22);
        check("gap_offset", 64'(o_bit_offset), 64'd19);
        step(0, $urandom, 0, 0);
        check("linkdown_locked", 64'(o_bit_locked), 64'd0);
        repeat (3) push_frame(0);
        drain(20, -1);
        check("linkup_relocked", 64'(o_bit_locked), 64'd1);

        // False HI in junk ahead of the real preamble.
        do_reset();
        push_bits(5);
        repeat (3) push_word($urandom);
        push_word(PRE_HI);
        push_word(PRE_LO ^ 32'h0000_0100);
        repeat (2) push_word($urandom);
        repeat (3) push_frame(0);
        drain(0, -1);
        check("falsehi_first_idx", 64'(first_hi_acc), 64'd4);
        check("falsehi_lock_idx", 64'(first_lock_acc), 64'd29);
        check("falsehi_offset", 64'(o_bit_offset), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
